// File: rtl/scan_doubler.sv
// Line doubler: each 15 kHz input line fills one bank of a ping-pong RAM while the other bank
// is replayed twice at the 2x pixel rate, optionally darkening the repeated copy.
module scan_doubler #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned HS_W    = 24,
  parameter int unsigned LEN_RST = 320
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PCLK_EN,
  input  logic        DCLK_EN,
  input  logic [11:0] iRGB,
  input  logic        HBLK,
  input  logic        VBLK,
  input  logic        HSYN,
  input  logic        VSYN,
  input  logic        SCANLN,
  output logic [11:0] oRGB,
  output logic        oHBLK,
  output logic        oVBLK,
  output logic        oHSYN,
  output logic        oVSYN,
  output logic        oLINE
);
  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] AddrMax = ADDR_W'(Depth - 1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  // Entry layout: {hblk, vblk, rgb}
  logic [13:0] mem [2*Depth];

  logic              wbank_q, wbank_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              hsyn_prev_q, hsyn_prev_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              line_q, line_d;
  logic [13:0]       rd_q, rd_d;
  logic              hs1_q, hs1_d;
  logic              vs1_q, vs1_d;
  logic              line1_q, line1_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              hblk_q, hblk_d;
  logic              vblk_q, vblk_d;
  logic              hsyn_q, hsyn_d;
  logic              vsyn_q, vsyn_d;

  logic              line_start;
  logic [ADDR_W:0]   wr_addr;
  logic [ADDR_W:0]   rd_addr;

  // Input side: capture pixels into the write bank.
  always_comb begin
    line_start  = PCLK_EN && hsyn_prev_q && !HSYN;
    wbank_d     = wbank_q;
    waddr_d     = waddr_q;
    len_d       = len_q;
    hsyn_prev_d = hsyn_prev_q;
    wr_addr     = {wbank_q, waddr_q};
    if (PCLK_EN) begin
      hsyn_prev_d = HSYN;
      if (line_start) begin
        len_d   = (waddr_q == '0) ? AddrOne : waddr_q;
        wbank_d = ~wbank_q;
        waddr_d = AddrOne;
        wr_addr = {~wbank_q, {ADDR_W{1'b0}}};
      end else if (waddr_q != AddrMax) begin
        waddr_d = waddr_q + AddrOne;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (PCLK_EN) begin
      mem[wr_addr] <= {HBLK, VBLK, iRGB};
    end
  end

  // Output side: read counter, registered RAM read, then registered output fields.
  always_comb begin
    rd_addr = {~wbank_q, raddr_q};
    raddr_d = raddr_q;
    line_d  = line_q;
    rd_d    = rd_q;
    hs1_d   = hs1_q;
    vs1_d   = vs1_q;
    line1_d = line1_q;
    rgb_d   = rgb_q;
    hblk_d  = hblk_q;
    vblk_d  = vblk_q;
    hsyn_d  = hsyn_q;
    vsyn_d  = vsyn_q;
    if (DCLK_EN) begin
      rd_d    = mem[rd_addr];
      hs1_d   = (raddr_q >= ADDR_W'(HS_W));
      line1_d = line_q;
      if (raddr_q == '0) begin
        vs1_d = VSYN;
      end
      if (raddr_q >= len_q - AddrOne) begin
        raddr_d = '0;
        line_d  = ~line_q;
      end else begin
        raddr_d = raddr_q + AddrOne;
      end
      hblk_d = rd_q[13];
      vblk_d = rd_q[12];
      hsyn_d = hs1_q;
      vsyn_d = vs1_q;
      if (rd_q[13] || rd_q[12]) begin
        rgb_d = '0;
      end else if (SCANLN && line1_q) begin
        rgb_d = {1'b0, rd_q[11:9], 1'b0, rd_q[7:5], 1'b0, rd_q[3:1]};
      end else begin
        rgb_d = rd_q[11:0];
      end
    end
    // A new input line always restarts the first copy.
    if (line_start) begin
      raddr_d = '0;
      line_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wbank_q     <= 1'b0;
      waddr_q     <= '0;
      len_q       <= ADDR_W'(LEN_RST);
      hsyn_prev_q <= 1'b1;
      raddr_q     <= '0;
      line_q      <= 1'b0;
      rd_q        <= 14'h3000;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      line1_q     <= 1'b0;
      rgb_q       <= '0;
      hblk_q      <= 1'b1;
      vblk_q      <= 1'b1;
      hsyn_q      <= 1'b1;
      vsyn_q      <= 1'b1;
    end else begin
      wbank_q     <= wbank_d;
      waddr_q     <= waddr_d;
      len_q       <= len_d;
      hsyn_prev_q <= hsyn_prev_d;
      raddr_q     <= raddr_d;
      line_q      <= line_d;
      rd_q        <= rd_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      line1_q     <= line1_d;
      rgb_q       <= rgb_d;
      hblk_q      <= hblk_d;
      vblk_q      <= vblk_d;
      hsyn_q      <= hsyn_d;
      vsyn_q      <= vsyn_d;
    end
  end

  assign oRGB  = rgb_q;
  assign oHBLK = hblk_q;
  assign oVBLK = vblk_q;
  assign oHSYN = hsyn_q;
  assign oVSYN = vsyn_q;
  assign oLINE = line_q;

endmodule

// File: tb/tb_scan_doubler.sv
// Bench for scan_doubler: random pixel lines drive a reference model whose expected output
// stream is queued and checked by an independent monitor on every output pixel tick.
module tb_scan_doubler;
  localparam int HsW = 24;

  logic        CLK = 1'b0;
  logic        RESET, PCLK_EN, DCLK_EN;
  logic [11:0] iRGB;
  logic        HBLK, VBLK, HSYN, VSYN, SCANLN;
  logic [11:0] oRGB;
  logic        oHBLK, oVBLK, oHSYN, oVSYN, oLINE;

  always #5 CLK = ~CLK;

  scan_doubler #(.ADDR_W(9), .HS_W(HsW), .LEN_RST(320)) dut (
    .CLK(CLK), .RESET(RESET), .PCLK_EN(PCLK_EN), .DCLK_EN(DCLK_EN), .iRGB(iRGB),
    .HBLK(HBLK), .VBLK(VBLK), .HSYN(HSYN), .VSYN(VSYN), .SCANLN(SCANLN),
    .oRGB(oRGB), .oHBLK(oHBLK), .oVBLK(oVBLK), .oHSYN(oHSYN), .oVSYN(oVSYN), .oLINE(oLINE)
  );

  typedef struct { logic [13:0] data; bit known; logic hs; logic vs; logic line; } rd_t;
  typedef struct { logic [11:0] rgb; logic hb; logic vb; logic hs; logic vs; logic line;
                   bit known; } exp_t;

  rd_t         pipe[$];
  exp_t        sb[$];
  logic [13:0] m_bank [2][512];
  bit          m_valid [2][512];
  int          m_wb, m_wa, m_len, m_ra;
  logic        m_line, m_hprev, m_vcap;
  int          total = 0;
  int          bad = 0;
  int          n_data = 0;

  function automatic void model_reset();
    rd_t r;
    m_wb = 0; m_wa = 0; m_len = 320; m_ra = 0;
    m_line = 1'b0; m_hprev = 1'b1; m_vcap = 1'b1;
    r.data = 14'h3000; r.known = 1'b1; r.hs = 1'b1; r.vs = 1'b1; r.line = 1'b0;
    pipe.delete();
    pipe.push_back(r);
    sb.delete();
  endfunction

  // One clock of the reference: output tick first (reads old bank state), then input write.
  function automatic void model_step();
    rd_t  r, o;
    exp_t e;
    int   rb;
    bit   ls;
    ls = PCLK_EN && m_hprev && !HSYN;
    if (DCLK_EN) begin
      rb = 1 - m_wb;
      r.data = m_bank[rb][m_ra];
      r.known = m_valid[rb][m_ra];
      r.hs = (m_ra >= HsW);
      r.line = m_line;
      if (m_ra == 0) m_vcap = VSYN;
      r.vs = m_vcap;
      o = pipe.pop_front();
      pipe.push_back(r);
      e.hb = o.data[13]; e.vb = o.data[12]; e.hs = o.hs; e.vs = o.vs; e.known = o.known;
      if (o.data[13] || o.data[12]) e.rgb = 12'h000;
      else if (SCANLN && o.line) e.rgb = {o.data[11:8] >> 1, o.data[7:4] >> 1, o.data[3:0] >> 1};
      else e.rgb = o.data[11:0];
      if (m_ra >= m_len - 1) begin
        m_ra = 0;
        m_line = ~m_line;
      end else begin
        m_ra++;
      end
    end
    if (ls) begin
      m_ra = 0;
      m_line = 1'b0;
    end
    if (DCLK_EN) begin
      e.line = m_line;
      sb.push_back(e);
    end
    if (PCLK_EN) begin
      if (ls) begin
        m_len = (m_wa == 0) ? 1 : m_wa;
        m_wb = 1 - m_wb;
        m_wa = 0;
      end
      m_bank[m_wb][m_wa] = {HBLK, VBLK, iRGB};
      m_valid[m_wb][m_wa] = 1'b1;
      if (m_wa < 511) m_wa++;
      m_hprev = HSYN;
    end
  endfunction

  function automatic void chk(input string name, input logic [13:0] got, input logic [13:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_oRGB"}, {2'b00, oRGB}, 14'h0000);
    chk({tag, "_oHBLK"}, {13'd0, oHBLK}, 14'd1);
    chk({tag, "_oVBLK"}, {13'd0, oVBLK}, 14'd1);
    chk({tag, "_oHSYN"}, {13'd0, oHSYN}, 14'd1);
    chk({tag, "_oVSYN"}, {13'd0, oVSYN}, 14'd1);
    chk({tag, "_oLINE"}, {13'd0, oLINE}, 14'd0);
  endtask

  // One input pixel period: four clocks, PCLK_EN on the first, DCLK_EN on the first and third.
  task automatic pixel(input logic [11:0] rgb, input logic hb, input logic vb, input logic hs);
    @(negedge CLK);
    iRGB = rgb; HBLK = hb; VBLK = vb; HSYN = hs; PCLK_EN = 1'b1; DCLK_EN = 1'b1;
    if (!RESET) model_step();
    @(negedge CLK);
    PCLK_EN = 1'b0; DCLK_EN = 1'b0;
    @(negedge CLK);
    DCLK_EN = 1'b1;
    if (!RESET) model_step();
    @(negedge CLK);
    DCLK_EN = 1'b0;
  endtask

  // mode 0: rgb = index; 1: hblank on pixels 0..28, white elsewhere; 2: random rgb.
  task automatic send_line(input int n, input int mode, input logic vb, input int hs_lo,
                           input int vs_at);
    logic [11:0] px;
    logic        hb;
    for (int i = 0; i < n; i++) begin
      hb = 1'b0;
      if (mode == 0) px = 12'(i);
      else if (mode == 1) begin
        px = 12'hFFF;
        hb = (i <= 28);
      end else px = 12'($urandom);
      if (i == vs_at) VSYN = ~VSYN;
      pixel(px, hb, vb, (i < hs_lo) ? 1'b0 : 1'b1);
    end
  endtask

  task automatic mid_reset();
    @(posedge CLK);
    #3 RESET = 1'b1;
    #1 check_reset("mid_reset");
    @(negedge CLK);
    PCLK_EN = 1'b0; DCLK_EN = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  always @(posedge CLK) begin
    exp_t e;
    bit   ok;
    if (DCLK_EN && !RESET) begin
      #1;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL out_queue: got empty queue want an expected entry");
      end else begin
        e = sb.pop_front();
        ok = (oHSYN === e.hs) && (oVSYN === e.vs) && (oLINE === e.line);
        if (e.known) begin
          n_data++;
          ok = ok && (oRGB === e.rgb) && (oHBLK === e.hb) && (oVBLK === e.vb);
        end
        if (!ok) begin
          bad++;
          $display("FAIL out_tick t=%0t: got rgb=%h hb=%b vb=%b hs=%b vs=%b line=%b want rgb=%h hb=%b vb=%b hs=%b vs=%b line=%b data_checked=%0d",
                   $time, oRGB, oHBLK, oVBLK, oHSYN, oVSYN, oLINE,
                   e.rgb, e.hb, e.vb, e.hs, e.vs, e.line, e.known);
        end
      end
    end
  end

  initial begin
    int lens[6] = '{300, 320, 250, 410, 320, 1};
    RESET = 1'b0; PCLK_EN = 1'b0; DCLK_EN = 1'b0; iRGB = 12'h000;
    HBLK = 1'b0; VBLK = 1'b0; HSYN = 1'b1; VSYN = 1'b1; SCANLN = 1'b0;
    #2 RESET = 1'b1;
    #10 check_reset("init_reset");
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();

    // Free-running at the reset length before any sync edge.
    send_line(100, 0, 1'b0, 0, -1);
    for (int l = 0; l < 4; l++) begin
      SCANLN = 1'(l & 1);
      send_line(320, 0, 1'b0, 16, -1);
    end
    SCANLN = 1'b1; send_line(320, 1, 1'b0, 16, -1);
    SCANLN = 1'b1; send_line(320, 1, 1'b0, 16, -1);
    SCANLN = 1'b0; send_line(320, 1, 1'b0, 16, -1);
    SCANLN = 1'b1; send_line(320, 1, 1'b0, 16, -1);

    for (int k = 0; k < 6; k++) begin
      SCANLN = 1'($urandom & 1);
      send_line((k == 5) ? int'($urandom_range(200, 400)) : lens[k], 2, (k == 3), 16,
                (k == 1) ? 137 : ((k == 2) ? 55 : -1));
    end

    // Overlong line, then back to nominal.
    SCANLN = 1'b1;
    send_line(600, 2, 1'b0, 16, -1);
    send_line(320, 2, 1'b0, 16, -1);
    send_line(320, 2, 1'b0, 16, 200);
    send_line(320, 2, 1'b0, 16, -1);

    send_line(150, 2, 1'b0, 16, -1);
    mid_reset();
    send_line(200, 2, 1'b0, 0, -1);
    for (int l = 0; l < 3; l++) begin
      SCANLN = 1'($urandom & 1);
      send_line(320, 2, 1'b0, 16, -1);
    end

    repeat (4) @(negedge CLK);
    chk("data_ticks_checked", {13'd0, (n_data > 2000)}, 14'd1);
    chk("queue_drained", 14'(sb.size()), 14'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
